sig_monitor: RTL and testbench
==============================

// Module: sig_monitor
// PURPOSE
//  Synthesisable store-bus snooper replacing ad-hoc bench signature/halt logic.
//  Sits beside the data memory. Captures stores to NUM_CH signature addresses into a FIFO,
//  which a bench or UART drains over valid/ready.
//  A store to HALT_ADDR ends the run. An optional watchdog ends it on timeout.
// PARAMETERS
//  ADDR_W      32             store address width
//  DATA_W      32             store data width
//  NUM_CH      1              signature channels; ch k at SIG_BASE + 4*k
//  SIG_BASE    32'hFF000000   channel-0 signature address
//  HALT_ADDR   32'hCAFEBEEF   halt address
//  FIFO_DEPTH  16             signature FIFO entries, power of 2, >=2
//  TIMEOUT     500000         watchdog limit in cycles, >=2
// PORTS
//  clk          in   1                        clock, rising edge
//  rst          in   1                        synchronous, active-high reset
//  st_wr_n      in   1                        store strobe, active-low (Dmem wr convention)
//  st_addr      in   ADDR_W                   store address (memory-stage ALU result)
//  st_data      in   DATA_W                   store data
//  sig_valid    out  1                        FIFO head valid
//  sig_ready    in   1                        consumer accepts head
//  sig_data     out  DATA_W                   FIFO head data
//  sig_ch       out  CH_W=max(1,$clog2(NUM_CH))  FIFO head channel
//  fifo_level   out  $clog2(FIFO_DEPTH)+1     occupancy
//  overflow     out  1                        sticky: a signature was dropped
//  drop_cnt     out  16                       dropped-store count, saturates at 16'hFFFF
//  halted       out  1                        sticky: halt store seen
//  halt_code    out  DATA_W                   data of the halt store
//  timeout      out  1                        sticky: watchdog expired
//  done         out  1                        (halted|timeout) & FIFO empty
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state RUN, watchdog count 0. Reset mid-run discards FIFO contents.
//  Store = ~st_wr_n. Signature hit = store & st_addr in {SIG_BASE+4k}, k<NUM_CH.
//   Compare is the full word address; misaligned addresses do not hit.
//  Hit in RUN pushes {ch,st_data}. Entry is visible on sig_valid the next cycle (latency 1).
//  Pop when sig_valid & sig_ready. sig_data and sig_ch hold stable while valid & ~ready.
//  Full: a push is dropped, overflow is set, drop_cnt increments.
//   Exception: a same-cycle pop makes room, and the push is accepted.
//  Empty with push and no pop: no bypass; the entry appears next cycle.
//  Pointers wrap modulo FIFO_DEPTH. fifo_level in 0..FIFO_DEPTH.
//  FSM states, with transitions registered:
//   RUN -> HALT on a halt store; halted=1 and halt_code=st_data the next cycle.
//   RUN -> TMO when the watchdog count reaches TIMEOUT-1; timeout=1 the next cycle.
//   HALT and TMO are terminal until rst.
//  In HALT/TMO, new signature stores are ignored (not pushed, not counted as drops).
//   Draining continues in these states.
//  Halt store and watchdog expiry in the same cycle: HALT wins, timeout stays 0.
//  A store to HALT_ADDR that also matches a signature address is treated as halt only.
//  done is combinational from the state and FIFO empty.
// CONFIGURATION
//  SIGMON_WATCHDOG_EN defined:
//   - the watchdog counter counts every cycle in RUN from reset release;
//   - the TMO state exists.
//  SIGMON_WATCHDOG_EN undefined:
//   - no counter;
//   - timeout tied to 0 and TMO unreachable;
//   - the run ends only on halt.
// STRUCTURE
//  Package sigmon_pkg holds:
//   - state_e {RUN,HALT,TMO};
//   - default SIG_BASE, HALT_ADDR and TIMEOUT localparams;
//   - the CH_W helper function.
//  Sub-module sig_fifo is a parametrised sync FIFO over DATA_W+CH_W-bit entries.
//   It provides push, pop, full, empty and level.
//  Decode, the FSM, the watchdog and the drop counter live in sig_monitor.
// TESTING
//  1 Reset then idle 10 cycles -> all outputs 0 and done=0.
//  2 NUM_CH=2: store 0xA5 @FF000000, then 0x5A @FF000004, sig_ready=1
//    -> pops (A5,ch0) then (5A,ch1), each 1 cycle after its store.
//  3 FIFO_DEPTH=4, sig_ready=0, 6 signature stores
//    -> level=4, overflow=1, drop_cnt=2. Then a store with a same-cycle pop
//    -> accepted, drop_cnt stays 2.
//  4 Store 0x1 @CAFEBEEF with 3 entries queued
//    -> halted=1 and halt_code=1 next cycle. Later signature stores are ignored.
//    -> done=1 only after 3 pops.
//  5 SIGMON_WATCHDOG_EN, TIMEOUT=100, no halt -> timeout=1 on cycle 100 after reset release, done=1.
//    Halt store on expiry cycle -> halted=1 and timeout=0.
//  6 Assert rst with entries queued -> next cycle sig_valid=0, level=0, sticky flags cleared.

Source files
------------

// File: rtl/sigmon_pkg.sv
// Shared types and defaults for the store-bus signature/halt monitor.
package sigmon_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    TMO  = 2'd2
  } state_e;

  localparam logic [31:0] SIG_BASE_DEF  = 32'hFF00_0000;
  localparam logic [31:0] HALT_ADDR_DEF = 32'hCAFE_BEEF;
  localparam int          TIMEOUT_DEF   = 500000;

  // Channel-id width; a single channel still gets one bit.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/sig_fifo.sv
// Synchronous FIFO for signature entries; a pop in the same cycle frees room for a push.
module sig_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             wr_en, rd_en;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == LW'(DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_en    = push_i & (~full_o | pop_i);
  assign rd_en    = pop_i & ~empty_o;
  assign wr_ptr_d = wr_en ? wr_ptr_q + LW'(1) : wr_ptr_q;
  assign rd_ptr_d = rd_en ? rd_ptr_q + LW'(1) : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sig_monitor.sv
// Store-bus snooper: queues signature stores, ends the run on a halt store or watchdog expiry.
// Optional watchdog enabled by defining SIGMON_WATCHDOG_EN.
module sig_monitor
  import sigmon_pkg::*;
#(
  parameter  int                ADDR_W     = 32,
  parameter  int                DATA_W     = 32,
  parameter  int                NUM_CH     = 1,
  parameter  logic [ADDR_W-1:0] SIG_BASE   = ADDR_W'(SIG_BASE_DEF),
  parameter  logic [ADDR_W-1:0] HALT_ADDR  = ADDR_W'(HALT_ADDR_DEF),
  parameter  int                FIFO_DEPTH = 16,
  parameter  int                TIMEOUT    = TIMEOUT_DEF,
  localparam int                CH_W       = ch_w(NUM_CH),
  localparam int                LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_wr_n,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [DATA_W-1:0] sig_data,
  output logic [CH_W-1:0]   sig_ch,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic [15:0]       drop_cnt,
  output logic              halted,
  output logic [DATA_W-1:0] halt_code,
  output logic              timeout,
  output logic              done
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   halt_code_q, halt_code_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  logic                store, halt_hit, sig_match, sig_hit, running;
  logic                push, pop, drop, wd_expire;
  logic                fifo_full, fifo_empty;
  logic [CH_W-1:0]     match_ch;
  logic [CH_W+DATA_W-1:0] fifo_rdata;

  assign store    = ~st_wr_n;
  assign halt_hit = store & (st_addr == HALT_ADDR);
  assign running  = (state_q == RUN);

  always_comb begin
    sig_match = 1'b0;
    match_ch  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (st_addr == SIG_BASE + (ADDR_W'(k) << 2)) begin
        sig_match = 1'b1;
        match_ch  = CH_W'(k);
      end
    end
  end

  // A halt address that aliases a signature slot is a halt only.
  assign sig_hit = store & sig_match & ~halt_hit;
  assign push    = sig_hit & running;
  assign pop     = sig_valid & sig_ready;
  assign drop    = push & fifo_full & ~pop;

  sig_fifo #(
    .WIDTH (CH_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({match_ch, st_data}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign sig_valid = ~fifo_empty;
  assign sig_data  = fifo_rdata[DATA_W-1:0];
  assign sig_ch    = fifo_rdata[DATA_W +: CH_W];

`ifdef SIGMON_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  assign wd_expire = running & (wd_cnt_q == WD_W'(TIMEOUT - 1));
  assign wd_cnt_d  = (running & ~wd_expire) ? wd_cnt_q + WD_W'(1) : wd_cnt_q;
  assign timeout   = (state_q == TMO);

  always_ff @(posedge clk) begin
    if (rst) wd_cnt_q <= '0;
    else     wd_cnt_q <= wd_cnt_d;
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // NOTE: every _d is given its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    halt_code_d = halt_code_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    case (state_q)
      RUN: begin
        if (halt_hit) begin
          state_d     = HALT;
          halt_code_d = st_data;
        end else if (wd_expire) begin
          state_d = TMO;
        end
      end
      default: state_d = state_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      halt_code_q <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      halt_code_q <= halt_code_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign halted    = (state_q == HALT);
  assign halt_code = halt_code_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign done      = ~running & fifo_empty;

endmodule

// File: tb/tb_sig_monitor.sv
// Scoreboard bench for sig_monitor (NUM_CH=2, FIFO_DEPTH=4, TIMEOUT=100).
module tb_sig_monitor;

  localparam int          DATA_W  = 32;
  localparam int          CH_W    = 1;
  localparam int          DEPTH   = 4;
  localparam int          TMO_LIM = 100;
  localparam logic [31:0] SIG0    = 32'hFF00_0000;
  localparam logic [31:0] SIG1    = 32'hFF00_0004;
  localparam logic [31:0] HALTA   = 32'hCAFE_BEEF;

  logic              clk = 1'b0;
  logic              rst;
  logic              st_wr_n;
  logic [31:0]       st_addr;
  logic [DATA_W-1:0] st_data;
  logic              sig_valid, sig_ready;
  logic [DATA_W-1:0] sig_data;
  logic [CH_W-1:0]   sig_ch;
  logic [2:0]        fifo_level;
  logic              overflow;
  logic [15:0]       drop_cnt;
  logic              halted;
  logic [DATA_W-1:0] halt_code;
  logic              timeout;
  logic              done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CH_W+DATA_W-1:0] sb_q[$];
  logic        m_ovf, m_halted, m_tmo;
  logic [15:0] m_drops;
  logic [31:0] m_code;
  int          m_cnt;

  always #5 clk = ~clk;

  sig_monitor #(
    .NUM_CH     (2),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO_LIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .st_wr_n    (st_wr_n),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .sig_valid  (sig_valid),
    .sig_ready  (sig_ready),
    .sig_data   (sig_data),
    .sig_ch     (sig_ch),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .halted     (halted),
    .halt_code  (halt_code),
    .timeout    (timeout),
    .done       (done)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    st_wr_n = 1'b1;
    st_addr = '0;
    st_data = '0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    st_wr_n = 1'b0;
    st_addr = addr;
    st_data = data;
  endtask

  // Compare outputs mid-cycle, then advance the model across the next rising edge.
  task automatic tick();
    logic                   pop, stor, hhit, shit, run;
    logic [CH_W+DATA_W-1:0] head;
    logic [CH_W-1:0]        ch;
    @(negedge clk);
    check("sig_valid", sig_valid, sb_q.size() != 0);
    check("fifo_level", fifo_level, sb_q.size());
    check("overflow", overflow, m_ovf);
    check("drop_cnt", drop_cnt, m_drops);
    check("halted", halted, m_halted);
    check("halt_code", halt_code, m_code);
    check("timeout", timeout, m_tmo);
    check("done", done, (m_halted | m_tmo) && sb_q.size() == 0);
    pop = sig_ready && sb_q.size() != 0;
    if (pop) begin
      head = sb_q.pop_front();
      check("sig_data", sig_data, head[DATA_W-1:0]);
      check("sig_ch", sig_ch, head[DATA_W +: CH_W]);
    end
    stor = !st_wr_n;
    hhit = stor && st_addr == HALTA;
    shit = stor && !hhit && (st_addr == SIG0 || st_addr == SIG1);
    ch   = CH_W'(st_addr == SIG1);
    run  = !m_halted && !m_tmo;
    if (shit && run) begin
      if (sb_q.size() < DEPTH) sb_q.push_back({ch, st_data});
      else begin
        m_ovf = 1'b1;
        if (m_drops != 16'hFFFF) m_drops++;
      end
    end
    if (run && hhit) begin
      m_halted = 1'b1;
      m_code   = st_data;
    end
`ifdef SIGMON_WATCHDOG_EN
    else if (run && m_cnt == TMO_LIM - 1) m_tmo = 1'b1;
    if (run) m_cnt++;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    sig_ready = 1'b0;
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    m_ovf    = 1'b0;
    m_halted = 1'b0;
    m_tmo    = 1'b0;
    m_drops  = '0;
    m_code   = '0;
    m_cnt    = 0;
  endtask

  initial begin
    // 1: reset and idle
    do_reset();
    repeat (10) tick();
    check("t1_done", done, 1'b0);
    check("t1_valid", sig_valid, 1'b0);

    // 2: two channels drained back to back
    do_reset();
    sig_ready = 1'b1;
    store(SIG0, 32'hA5); tick();
    store(SIG1, 32'h5A); tick();
    idle();
    repeat (3) tick();
    check("t2_level", fifo_level, 3'd0);

    // 3: overflow, then a push alongside a pop is accepted
    do_reset();
    for (int i = 0; i < 6; i++) begin
      store(SIG0, 32'h100 + i);
      tick();
    end
    idle(); tick();
    check("t3_level", fifo_level, 3'd4);
    check("t3_ovf", overflow, 1'b1);
    check("t3_drops", drop_cnt, 16'd2);
    sig_ready = 1'b1;
    store(SIG1, 32'h77); tick();
    sig_ready = 1'b0;
    idle(); tick();
    check("t3_drops_hold", drop_cnt, 16'd2);
    check("t3_level_full", fifo_level, 3'd4);
    sig_ready = 1'b1;
    repeat (5) tick();

    // 4: halt with entries queued, later stores ignored, done after drain
    do_reset();
    for (int i = 0; i < 3; i++) begin
      store(SIG0, 32'h10 + i);
      tick();
    end
    store(HALTA, 32'h1); tick();
    check("t4_halted", halted, 1'b1);
    check("t4_code", halt_code, 32'h1);
    store(SIG1, 32'h99); tick();
    idle();
    check("t4_level", fifo_level, 3'd3);
    check("t4_nodrop", drop_cnt, 16'd0);
    check("t4_done_early", done, 1'b0);
    sig_ready = 1'b1;
    repeat (3) tick();
    check("t4_done", done, 1'b1);
    tick();

    // 5: watchdog
`ifdef SIGMON_WATCHDOG_EN
    do_reset();
    repeat (TMO_LIM - 1) tick();
    check("t5_tmo_early", timeout, 1'b0);
    tick();
    check("t5_tmo", timeout, 1'b1);
    check("t5_done", done, 1'b1);
    do_reset();
    repeat (TMO_LIM - 1) tick();
    store(HALTA, 32'h7); tick();
    idle();
    check("t5_halt_wins", halted, 1'b1);
    check("t5_no_tmo", timeout, 1'b0);
    check("t5_code", halt_code, 32'h7);
`else
    do_reset();
    repeat (150) tick();
    check("t5_no_watchdog", timeout, 1'b0);
    check("t5_not_done", done, 1'b0);
`endif

    // 6: reset mid-run clears queue and sticky flags
    do_reset();
    for (int i = 0; i < 5; i++) begin
      store(SIG0, 32'h200 + i);
      tick();
    end
    store(HALTA, 32'h3); tick();
    idle(); tick();
    do_reset();
    check("t6_valid", sig_valid, 1'b0);
    check("t6_level", fifo_level, 3'd0);
    check("t6_ovf", overflow, 1'b0);
    check("t6_drops", drop_cnt, 16'd0);
    check("t6_halted", halted, 1'b0);
    check("t6_code", halt_code, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
